// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencing and buffering around the UART receiver datapath.
//
// - Baud generator: produces the 16x-oversample s_tick every baud_div+1 clk
//   cycles while baud_en is high.
// - Byte FIFO: buffers rx_data on rx_done_tick and presents the head byte on a
//   registered valid/ready interface; a byte arriving while full is dropped
//   and flagged on the sticky overrun output.
// - Idle timeout (built only when UART_RX_CTRL_TIMEOUT_EN is defined): pulses
//   frame_end once after TIMEOUT_BITS bit-times of line idle following a byte.
//   Without the macro frame_end is tied low.
//
// Timeout FSM states:
//   state     | meaning
//   ST_IDLE   | no byte since the last timeout or reset, timer stopped
//   ST_ACTIVE | byte seen, counting s_ticks toward frame_end
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   baud_en, baud_div    tick enable and tick period minus 1 (clk cycles)
//   s_tick               oversample tick to the receiver
//   rx_done_tick/rx_data byte-complete pulse and byte from the receiver
//   m_data/m_valid/m_ready  FIFO head byte handshake to the consumer
//   fifo_count           current FIFO occupancy
//   overrun/overrun_clr  sticky byte-dropped flag and its clear
//   frame_end            one-cycle idle-timeout pulse
module uart_rx_ctrl #(
    parameter int DIV_W        = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_BITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          baud_en,
    input  logic [DIV_W-1:0]              baud_div,
    output logic                          s_tick,
    input  logic                          rx_done_tick,
    input  logic [7:0]                    rx_data,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic                          frame_end
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_ctrl: FIFO_DEPTH must be a power of 2 in 2..16");
    end
    if (TIMEOUT_BITS < 1 || TIMEOUT_BITS > 255) begin : g_bad_timeout
        $error("uart_rx_ctrl: TIMEOUT_BITS must be in 1..255");
    end

    // ---------------- baud generator ----------------
    logic [DIV_W-1:0] bcnt_q, bcnt_d;
    logic             s_tick_q, s_tick_d;

    // >= rather than == so that lowering baud_div below bcnt wraps immediately.
    always_comb begin
        bcnt_d   = '0;
        s_tick_d = 1'b0;
        if (baud_en) begin
            if (bcnt_q >= baud_div) begin
                s_tick_d = 1'b1;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt_q   <= '0;
            s_tick_q <= 1'b0;
        end else begin
            bcnt_q   <= bcnt_d;
            s_tick_q <= s_tick_d;
        end
    end

    assign s_tick = s_tick_q;

    // ---------------- byte FIFO ----------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             overrun_q, overrun_d;
    logic             full, do_pop, do_push, drop;

    always_comb begin
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        do_pop  = m_valid_q & m_ready;
        // A pop in the same cycle frees the slot, so full+push+pop is accepted.
        do_push = rx_done_tick & (~full | do_pop);
        drop    = rx_done_tick & full & ~do_pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = rx_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end

        // Output register is loaded from the post-update head so a byte into an
        // empty FIFO is visible one cycle after rx_done_tick.
        m_valid_d = (count_d != '0);
        m_data_d  = mem_d[rd_ptr_d];

        overrun_d = overrun_q;
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;

    // ---------------- idle timeout ----------------
`ifdef UART_RX_CTRL_TIMEOUT_EN
    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } to_state_e;

    localparam int              TC_W    = 12;
    localparam logic [TC_W-1:0] TC_LOAD = TC_W'(TIMEOUT_BITS * 16 - 1);

    to_state_e       state_q, state_d;
    // Down-counter: loaded with the tick budget on each byte, fires at zero.
    logic [TC_W-1:0] tcnt_q, tcnt_d;
    logic            frame_end_q, frame_end_d;

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        frame_end_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_done_tick) begin
                    state_d = ST_ACTIVE;
                    tcnt_d  = TC_LOAD;
                end
            end
            ST_ACTIVE: begin
                // A byte arriving on the expiry tick takes priority.
                if (rx_done_tick) begin
                    tcnt_d = TC_LOAD;
                end else if (s_tick_q) begin
                    if (tcnt_q == '0) begin
                        frame_end_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign frame_end = frame_end_q;
`else
    assign frame_end = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: scoreboard queue of bytes expected at the FIFO
// output, plus direct checks on tick timing, overrun and the idle timeout.
module tb_uart_rx_ctrl;

    localparam int DIV_W = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             baud_en;
    logic [DIV_W-1:0] baud_div;
    logic             s_tick;
    logic             rx_done_tick;
    logic [7:0]       rx_data;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready;
    logic [2:0]       fifo_count;
    logic             overrun;
    logic             overrun_clr;
    logic             frame_end;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [7:0]  exp_q[$];
    logic        exp_ovr = 1'b0;
    int          pops = 0;

    uart_rx_ctrl #(
        .DIV_W       (DIV_W),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_BITS(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_en     (baud_en),
        .baud_div    (baud_div),
        .s_tick      (s_tick),
        .rx_done_tick(rx_done_tick),
        .rx_data     (rx_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .fifo_count  (fifo_count),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .frame_end   (frame_end)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Update the model from the inputs about to be sampled, advance one clock,
    // then compare outputs 1 time unit after the edge.
    task automatic step();
        logic [7:0] head;
        if (reset) begin
            exp_q.delete();
            exp_ovr = 1'b0;
        end else begin
            if (exp_q.size() != 0 && m_ready) begin
                head = exp_q.pop_front();
                check_val("m_data_pop", m_data, head);
                pops++;
            end
            if (overrun_clr) exp_ovr = 1'b0;
            if (rx_done_tick) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(rx_data);
                else exp_ovr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_val("fifo_count", fifo_count, exp_q.size());
        check_val("m_valid", m_valid, exp_q.size() != 0);
        check_val("overrun", overrun, exp_ovr);
        if (exp_q.size() != 0) check_val("m_data_head", m_data, exp_q[0]);
`ifndef UART_RX_CTRL_TIMEOUT_EN
        check_val("frame_end_off", frame_end, 1'b0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        baud_en      = 1'b0;
        baud_div     = '0;
        rx_done_tick = 1'b0;
        rx_data      = '0;
        m_ready      = 1'b0;
        overrun_clr  = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_val("rst_s_tick", s_tick, 1'b0);
        check_val("rst_m_valid", m_valid, 1'b0);
        check_val("rst_m_data", m_data, 8'h00);
        check_val("rst_count", fifo_count, 3'd0);
        check_val("rst_overrun", overrun, 1'b0);
        check_val("rst_frame_end", frame_end, 1'b0);

        // Tick period 4 with baud_div=3, first tick after the 4th edge.
        baud_en  = 1'b1;
        baud_div = 16'd3;
        for (int i = 1; i <= 20; i++) begin
            step();
            check_val("tick_div3", s_tick, (i % 4) == 0);
        end
        baud_div = 16'd0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_val("tick_div0", s_tick, 1'b1);
        end
        baud_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_val("tick_disabled", s_tick, 1'b0);
        end
        // Re-enable: counter restarts from 0; then lower divisor below bcnt.
        baud_en  = 1'b1;
        baud_div = 16'd10;
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("tick_div10", s_tick, 1'b0);
        end
        baud_div = 16'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("tick_lowered", s_tick, (i == 0) || (i == 3));
        end
        baud_en = 1'b0;
        step();

        // Single byte held until accepted.
        rx_data      = 8'hA5;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
        check_val("single_valid", m_valid, 1'b1);
        check_val("single_data", m_data, 8'hA5);
        check_val("single_count", fifo_count, 3'd1);
        repeat (3) step();
        check_val("single_hold", m_data, 8'hA5);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check_val("single_popped_valid", m_valid, 1'b0);
        check_val("single_popped_count", fifo_count, 3'd0);

        // Ordering and pointer wrap with bursty m_ready.
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            rx_done_tick = (i % 2) == 0;
            rx_data      = 8'(i / 2 + 1);
            m_ready      = (i % 6) < 4;
            step();
        end
        rx_done_tick = 1'b0;
        m_ready      = 1'b1;
        repeat (4) step();
        check_val("order_pops", pops, 10);
        check_val("order_no_ovr", overrun, 1'b0);
        check_val("order_empty", fifo_count, 3'd0);

        // Empty FIFO with push and m_ready together: no pop that cycle.
        rx_data      = 8'h33;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
        check_val("empty_push_ready_count", fifo_count, 3'd1);
        step();
        m_ready = 1'b0;
        check_val("empty_push_ready_drained", fifo_count, 3'd0);

        // Overrun: fifth byte dropped.
        for (int i = 0; i < 5; i++) begin
            rx_data      = 8'(8'h10 + i);
            rx_done_tick = 1'b1;
            step();
        end
        rx_done_tick = 1'b0;
        check_val("ovr_count", fifo_count, 3'd4);
        check_val("ovr_flag", overrun, 1'b1);
        check_val("ovr_head", m_data, 8'h10);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check_val("ovr_cleared", overrun, 1'b0);
        rx_data      = 8'h20;
        rx_done_tick = 1'b1;
        m_ready      = 1'b1;
        step();
        rx_done_tick = 1'b0;
        m_ready      = 1'b0;
        check_val("full_push_pop_count", fifo_count, 3'd4);
        check_val("full_push_pop_no_ovr", overrun, 1'b0);
        check_val("full_push_pop_head", m_data, 8'h11);
        rx_data      = 8'h21;
        rx_done_tick = 1'b1;
        overrun_clr  = 1'b1;
        step();
        rx_done_tick = 1'b0;
        overrun_clr  = 1'b0;
        check_val("ovr_set_wins", overrun, 1'b1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        m_ready     = 1'b1;
        repeat (5) step();
        m_ready = 1'b0;
        check_val("ovr_drained", fifo_count, 3'd0);

        // Reset mid-operation with buffered bytes, overrun and running ticks.
        baud_en  = 1'b1;
        baud_div = 16'd0;
        for (int i = 0; i < 5; i++) begin
            rx_data      = 8'(8'hC0 + i);
            rx_done_tick = 1'b1;
            step();
        end
        rx_done_tick = 1'b0;
        check_val("pre_rst_count", fifo_count, 3'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("mid_rst_s_tick", s_tick, 1'b0);
        check_val("mid_rst_m_valid", m_valid, 1'b0);
        check_val("mid_rst_m_data", m_data, 8'h00);
        check_val("mid_rst_count", fifo_count, 3'd0);
        check_val("mid_rst_overrun", overrun, 1'b0);
        check_val("mid_rst_frame_end", frame_end, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step();
            check_val("frame_end_after_rst", frame_end, 1'b0);
        end

`ifdef UART_RX_CTRL_TIMEOUT_EN
        // One byte then idle: pulse 64 ticks later.
        m_ready      = 1'b1;
        rx_data      = 8'h5A;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            step();
            check_val("frame_end_single", frame_end, k == 64);
        end
        // Second byte on the expiry tick: no pulse, timer restarts.
        rx_data      = 8'h6B;
        rx_done_tick = 1'b1;
        step();
        for (int k = 1; k <= 140; k++) begin
            rx_done_tick = (k == 64);
            rx_data      = 8'h70;
            step();
            check_val("frame_end_restart", frame_end, k == 128);
        end
        rx_done_tick = 1'b0;
        m_ready      = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
